// File: rtl/apb_mem_bridge_pkg.sv
// Shared types and helpers for the APB-to-memory bridge.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_e;

    localparam int unsigned APB_DW = 32;

    // 32-bit lane index of a byte address within a dw-bit memory word.
    function automatic int unsigned lane_of(input logic [63:0] paddr, input int unsigned dw);
        logic [63:0] word_idx;
        logic [63:0] lane_mask;
        word_idx  = paddr >> 2;
        lane_mask = 64'(dw / APB_DW) - 64'd1;
        return 32'(word_idx & lane_mask);
    endfunction

endpackage

// File: rtl/apb_mem_bridge_if.sv
// APB4 completer port and generic memory-wrapper port of the bridge.
interface apb_mem_bridge_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    import apb_mem_pkg::*;

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [AW-1:0]       paddr;
    logic [APB_DW-1:0]   pwdata;
    logic [3:0]          pstrb;
    logic [APB_DW-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    logic                mem_req;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW/8-1:0]     mem_wstrb;
    logic [DW-1:0]       mem_rdata;
    logic                mem_rdata_valid;

    // Bridge side.
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_rdata_valid
    );

    // APB requester plus memory model side.
    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_rdata_valid
    );

endinterface

// File: rtl/apb_mem_bridge.sv
// APB4 completer turning single transfers into one-shot memory requests,
// with lane steering, alignment/strobe checks and a completion timeout.
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    apb_mem_bridge_if.slave  bus
);

    localparam int unsigned SW     = DW / 8;
    localparam int unsigned NLANES = DW / APB_DW;
    localparam int unsigned LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned CNT_W  = 8;

    bridge_state_e       state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [LANE_W-1:0]   lane_q, lane_nxt, req_lane;
    logic                write_q, write_nxt;
    logic                req_err;

    logic [APB_DW-1:0]   prdata_q, prdata_nxt;
    logic                pready_q, pready_nxt;
    logic                pslverr_q, pslverr_nxt;
    logic                mem_req_q, mem_req_nxt;
    logic                mem_we_q, mem_we_nxt;
    logic [AW-1:0]       mem_addr_q, mem_addr_nxt;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_nxt;
    logic [SW-1:0]       mem_wstrb_q, mem_wstrb_nxt;

    assign req_lane = LANE_W'(lane_of(64'(bus.paddr), DW));
    assign req_err  = (bus.paddr[1:0] != 2'b00) || (!bus.pwrite && (bus.pstrb != 4'h0));
    assign cnt_inc  = cnt + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lane_nxt      = lane_q;
        write_nxt     = write_q;
        prdata_nxt    = prdata_q;
        pready_nxt    = 1'b0;
        pslverr_nxt   = pslverr_q;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        mem_wstrb_nxt = mem_wstrb_q;

        case (state)
            IDLE: begin
                if (bus.psel && bus.penable) begin
                    lane_nxt  = req_lane;
                    write_nxt = bus.pwrite;
                    if (req_err) begin
                        state_nxt   = RESP;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                        prdata_nxt  = '0;
                    end else begin
                        state_nxt     = ISSUE;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = bus.pwrite;
                        mem_addr_nxt  = bus.paddr & ~AW'(SW - 1);
                        mem_wdata_nxt = {NLANES{bus.pwdata}};
                        mem_wstrb_nxt = SW'(bus.pstrb) << (req_lane * 4);
                    end
                end
            end

            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end

            // Completion wins over a coincident timeout.
            WAIT: begin
                cnt_nxt = cnt_inc;
                if (bus.mem_rdata_valid) begin
                    state_nxt     = RESP;
                    pready_nxt    = 1'b1;
                    pslverr_nxt   = 1'b0;
                    prdata_nxt    = write_q ? '0
                                            : APB_DW'(bus.mem_rdata >> (lane_q * APB_DW));
                    mem_addr_nxt  = '0;
                    mem_wdata_nxt = '0;
                    mem_wstrb_nxt = '0;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_nxt     = RESP;
                    pready_nxt    = 1'b1;
                    pslverr_nxt   = 1'b1;
                    prdata_nxt    = '0;
                    mem_addr_nxt  = '0;
                    mem_wdata_nxt = '0;
                    mem_wstrb_nxt = '0;
                end
            end

            RESP: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                prdata_nxt  = '0;
                pslverr_nxt = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lane_q      <= '0;
            write_q     <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lane_q      <= lane_nxt;
            write_q     <= write_nxt;
            prdata_q    <= prdata_nxt;
            pready_q    <= pready_nxt;
            pslverr_q   <= pslverr_nxt;
            mem_req_q   <= mem_req_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            mem_wstrb_q <= mem_wstrb_nxt;
        end
    end

    assign bus.prdata    = prdata_q;
    assign bus.pready    = pready_q;
    assign bus.pslverr   = pslverr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed plus randomized APB transfers against a byte-level memory model.
module tb_apb_mem_bridge;
    import apb_mem_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_mem_bridge_if #(.AW(AW), .DW(DW)) bus ();

    apb_mem_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] mem_model [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [31:0] wa);
        return mem_model.exists(wa) ? mem_model[wa] : 64'h0;
    endfunction

    // One APB transfer; dly = WAIT cycle (1-based) on which memory answers, 0 = never.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int dly);
        logic        err, exp_err;
        int          lane, resp_k;
        logic [31:0] wa, exp_rd;
        logic [7:0]  exp_strb;
        logic [63:0] word;

        err      = (addr[1:0] != 2'b00) || (!wr && st != 4'h0);
        lane     = int'(addr[2]);
        wa       = addr & ~32'h7;
        exp_strb = 8'(st) << (4 * lane);
        word     = mem_rd(wa);
        if (err) begin
            resp_k = 1; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (dly >= 1 && dly <= int'(TO)) begin
            resp_k = 2 + dly; exp_err = 1'b0;
            exp_rd = wr ? 32'h0 : (lane == 1 ? word[63:32] : word[31:0]);
        end else begin
            resp_k = 2 + int'(TO); exp_err = 1'b1; exp_rd = 32'h0;
        end

        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = wd; bus.pstrb = st;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        check("idle_quiet", {63'h0, bus.pready | bus.mem_req}, 64'h0);

        for (int k = 1; k <= resp_k; k++) begin
            @(posedge clk); #1;
            bus.mem_rdata_valid = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
            if (k == 1 && !err) begin
                check("issue_req",   {63'h0, bus.mem_req}, 64'h1);
                check("issue_we",    {63'h0, bus.mem_we}, {63'h0, wr});
                check("issue_addr",  64'(bus.mem_addr), 64'(wa));
                check("issue_wdata", bus.mem_wdata, {wd, wd});
                check("issue_wstrb", 64'(bus.mem_wstrb), 64'(exp_strb));
                if (wr) begin
                    word = mem_rd(wa);
                    for (int b = 0; b < 8; b++)
                        if (exp_strb[b]) word[8*b +: 8] = wd[8*(b%4) +: 8];
                    mem_model[wa] = word;
                end
            end else if (k < resp_k) begin
                check("wait_req",  {63'h0, bus.mem_req | bus.mem_we}, 64'h0);
                check("wait_addr", 64'(bus.mem_addr), 64'(wa));
            end else if (err) begin
                check("err_no_req", {63'h0, bus.mem_req}, 64'h0);
            end

            if (k < resp_k) begin
                check("pready_early", {63'h0, bus.pready}, 64'h0);
                if (!err && k >= 2 && (k - 1) == dly) begin
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata = mem_rd(wa);
                end
            end else begin
                check("pready",  {63'h0, bus.pready}, 64'h1);
                check("pslverr", {63'h0, bus.pslverr}, {63'h0, exp_err});
                check("prdata",  64'(bus.prdata), 64'(exp_rd));
            end
        end

        bus.psel = 1'b0; bus.penable = 1'b0; bus.mem_rdata_valid = 1'b0;
        @(posedge clk); #1;
        check("resp_clear", {31'h0, bus.pready, bus.pslverr, bus.prdata}, 64'h0);
    endtask

    initial begin
        logic        wr, mis;
        logic [31:0] addr;
        logic [3:0]  st;

        rst = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_apb", {31'h0, bus.pready, bus.pslverr, bus.prdata}, 64'h0);
        check("rst_mem_ctl", {62'h0, bus.mem_req, bus.mem_we}, 64'h0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rst_mem_wdata", bus.mem_wdata, 64'h0);
        check("rst_mem_wstrb", 64'(bus.mem_wstrb), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Lane-steered writes and read-back.
        xfer(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 2);
        xfer(1'b1, 32'h100, 32'h11223344, 4'hF, 2);
        xfer(1'b0, 32'h104, 32'h0, 4'h0, 2);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 2);

        // Misaligned and illegal-strobe errors.
        xfer(1'b1, 32'h102, 32'hCAFEF00D, 4'hF, 2);
        xfer(1'b0, 32'h104, 32'h0, 4'h1, 2);

        // Timeout, then an immediate normal transfer.
        xfer(1'b0, 32'h104, 32'h0, 4'h0, 0);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 1);

        // Completion on the last allowed WAIT cycle, and one before it.
        xfer(1'b0, 32'h104, 32'h0, 4'h0, int'(TO));
        xfer(1'b1, 32'h108, 32'h0BADF00D, 4'hF, int'(TO) - 1);

        // No-op write, then partial strobes.
        xfer(1'b1, 32'h104, 32'hFFFFFFFF, 4'h0, 3);
        xfer(1'b0, 32'h104, 32'h0, 4'h0, 2);
        xfer(1'b1, 32'h10C, 32'hA5A55A5A, 4'b0101, 2);
        xfer(1'b0, 32'h10C, 32'h0, 4'h0, 2);
        xfer(1'b0, 32'h108, 32'h0, 4'h0, 4);

        // Reset while waiting on memory.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h304; bus.pwdata = 32'h12345678; bus.pstrb = 4'hF;
        @(posedge clk); #1; bus.penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_addr", 64'(bus.mem_addr), 64'h300);
        rst = 1'b1;
        #1;
        check("mid_rst_apb", {31'h0, bus.pready, bus.pslverr, bus.prdata}, 64'h0);
        check("mid_rst_mem", {bus.mem_req, bus.mem_we, 30'(bus.mem_addr), bus.mem_wstrb,
                              24'(bus.mem_wdata)}, 64'h0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_quiet", {63'h0, bus.pready}, 64'h0);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 2);

        // Stray completion while idle must be ignored.
        bus.mem_rdata_valid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rdata_valid = 1'b0;
        check("stray_valid_0", {62'h0, bus.pready, bus.mem_req}, 64'h0);
        @(posedge clk); #1;
        check("stray_valid_1", {63'h0, bus.pready}, 64'h0);

        // Randomized transfers in a small window.
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            mis  = ($urandom_range(0, 7) == 0);
            addr = 32'h200 + (32'($urandom_range(0, 15)) << 2);
            if (mis) addr = addr | 32'($urandom_range(1, 3));
            if (wr) st = 4'($urandom);
            else    st = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            xfer(wr, addr, $urandom, st, ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
